// File: rtl/bmf_adder_pkg.sv
// Shared definitions for the segmented approximate adder pipeline.
//   DEF_*        : default parameter values for bmf_adder_pipe
//   calc_nseg    : number of segments (and pipeline stages) for a given width
//   stage_ctl_t  : per-stage control record (valid, chain carries, error flag)
package bmf_adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SEG   = 8;
    localparam int unsigned DEF_CW    = 16;

    // WIDTH is expected to be an exact multiple of SEG
    function automatic int unsigned calc_nseg(input int unsigned width, input int unsigned seg);
        return width / seg;
    endfunction

    // Stage record; mode and partial sum are parameter-sized, so they are
    // carried in per-stage arrays alongside this record.
    typedef struct packed {
        logic valid;     // stage holds a live beat
        logic carry;     // carry-out of the (possibly cut) chain
        logic ex_carry;  // carry-out of the exact shadow chain
        logic err;       // some segment so far took a carry-in different from exact
    } stage_ctl_t;

endpackage

// File: rtl/bmf_adder_seg.sv
// One SEG-bit segment of the approximate adder (purely combinational).
//   a, b      : segment operand slices
//   approx    : 1 cuts the carry-in to zero
//   cin       : carry from the previous segment's approximate chain
//   ex_cin    : carry from the previous segment's exact shadow chain
//   sum_c     : segment sum using the effective carry-in
//   cout_c    : carry-out of the approximate chain
//   ex_cout_c : carry-out of the exact shadow chain
//   diff_c    : effective carry-in differs from exact one (segment sum is wrong)
module bmf_adder_seg #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           approx,
    input  logic           cin,
    input  logic           ex_cin,
    output logic [SEG-1:0] sum_c,
    output logic           cout_c,
    output logic           ex_cout_c,
    output logic           diff_c
);

    logic           cin_eff;
    logic [SEG:0]   raw;

    // A carry-in of 1 only ripples out when a+b is all ones in the low SEG bits,
    // so one a+b serves both chains.
    always_comb begin
        cin_eff   = cin & ~approx;
        raw       = {1'b0, a} + {1'b0, b};
        sum_c     = raw[SEG-1:0] + SEG'(cin_eff);
        cout_c    = raw[SEG] | (cin_eff & (&raw[SEG-1:0]));
        ex_cout_c = raw[SEG] | (ex_cin & (&raw[SEG-1:0]));
        diff_c    = cin_eff ^ ex_cin;
    end

endmodule

// File: rtl/bmf_adder_pipe.sv
// Segmented approximate adder, one pipeline stage per SEG-bit segment.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand handshake (in_ready = global advance)
//   in_a, in_b, in_cin   : operands and carry-in
//   in_mode              : per-segment carry-cut enable, travels with its beat
//   out_valid/out_ready  : result handshake
//   out_sum, out_cout    : approximate sum and top carry-out
//   out_err              : result differs from exact a+b+cin
//   clr_stats            : synchronous clear of the statistics counters
//   tot_cnt, err_cnt     : delivered / erroneous-delivered result counts (saturating)
module bmf_adder_pipe
    import bmf_adder_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned SEG   = DEF_SEG,
    parameter  int unsigned CW    = DEF_CW,
    localparam int unsigned NSEG  = calc_nseg(WIDTH, SEG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [NSEG-1:0]  in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_err,
    input  logic             clr_stats,
    output logic [CW-1:0]    tot_cnt,
    output logic [CW-1:0]    err_cnt
);

    logic [WIDTH-1:0] a_q    [NSEG];
    logic [WIDTH-1:0] a_d    [NSEG];
    logic [WIDTH-1:0] b_q    [NSEG];
    logic [WIDTH-1:0] b_d    [NSEG];
    logic [WIDTH-1:0] sum_q  [NSEG];
    logic [WIDTH-1:0] sum_d  [NSEG];
    logic [NSEG-1:0]  mode_q [NSEG];
    logic [NSEG-1:0]  mode_d [NSEG];
    stage_ctl_t       ctl_q  [NSEG];
    stage_ctl_t       ctl_d  [NSEG];

    // Stage inputs: stage 0 from the ports, stage i from stage i-1
    logic [WIDTH-1:0] src_a    [NSEG];
    logic [WIDTH-1:0] src_b    [NSEG];
    logic [WIDTH-1:0] src_sum  [NSEG];
    logic [NSEG-1:0]  src_mode [NSEG];
    stage_ctl_t       src_ctl  [NSEG];

    logic [SEG-1:0]   seg_sum     [NSEG];
    logic             seg_cout    [NSEG];
    logic             seg_ex_cout [NSEG];
    logic             seg_diff    [NSEG];

    logic             advance;
    logic             out_xfer;
    logic [CW-1:0]    tot_cnt_q, tot_cnt_d;
    logic [CW-1:0]    err_cnt_q, err_cnt_d;

    // Stage input selection
    always_comb begin
        src_a[0]    = in_a;
        src_b[0]    = in_b;
        src_sum[0]  = '0;
        src_mode[0] = in_mode;
        src_ctl[0]  = '{valid: in_valid, carry: in_cin, ex_carry: in_cin, err: 1'b0};
        for (int i = 1; i < NSEG; i++) begin
            src_a[i]    = a_q[i-1];
            src_b[i]    = b_q[i-1];
            src_sum[i]  = sum_q[i-1];
            src_mode[i] = mode_q[i-1];
            src_ctl[i]  = ctl_q[i-1];
        end
    end

    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        bmf_adder_seg #(.SEG(SEG)) u_seg (
            .a         (src_a[i][i*SEG +: SEG]),
            .b         (src_b[i][i*SEG +: SEG]),
            .approx    (src_mode[i][i]),
            .cin       (src_ctl[i].carry),
            .ex_cin    (src_ctl[i].ex_carry),
            .sum_c     (seg_sum[i]),
            .cout_c    (seg_cout[i]),
            .ex_cout_c (seg_ex_cout[i]),
            .diff_c    (seg_diff[i])
        );
    end

    // Whole pipe moves together; it freezes only when the output is held
    always_comb begin
        advance = out_ready | ~ctl_q[NSEG-1].valid;
        for (int i = 0; i < NSEG; i++) begin
            a_d[i]    = a_q[i];
            b_d[i]    = b_q[i];
            sum_d[i]  = sum_q[i];
            mode_d[i] = mode_q[i];
            ctl_d[i]  = ctl_q[i];
            if (advance) begin
                a_d[i]    = src_a[i];
                b_d[i]    = src_b[i];
                mode_d[i] = src_mode[i];
                sum_d[i]  = src_sum[i];
                sum_d[i][i*SEG +: SEG] = seg_sum[i];
                ctl_d[i]  = '{valid:    src_ctl[i].valid,
                              carry:    seg_cout[i],
                              ex_carry: seg_ex_cout[i],
                              err:      src_ctl[i].err | seg_diff[i]};
            end
        end
    end

    // Saturating statistics; clear takes priority over a same-cycle increment
    always_comb begin
        out_xfer  = ctl_q[NSEG-1].valid & out_ready;
        tot_cnt_d = tot_cnt_q;
        err_cnt_d = err_cnt_q;
        if (clr_stats) begin
            tot_cnt_d = '0;
            err_cnt_d = '0;
        end else if (out_xfer) begin
            if (tot_cnt_q != '1) begin
                tot_cnt_d = tot_cnt_q + CW'(1);
            end
            if (ctl_q[NSEG-1].err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CW'(1);
            end
        end
    end

    // Control state: valid bits and counters are reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSEG; i++) begin
                ctl_q[i] <= '0;
            end
            tot_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NSEG; i++) begin
                ctl_q[i] <= ctl_d[i];
            end
            tot_cnt_q <= tot_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Datapath registers carry no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSEG; i++) begin
            a_q[i]    <= a_d[i];
            b_q[i]    <= b_d[i];
            sum_q[i]  <= sum_d[i];
            mode_q[i] <= mode_d[i];
        end
    end

    assign in_ready  = advance;
    assign out_valid = ctl_q[NSEG-1].valid;
    assign out_sum   = sum_q[NSEG-1];
    assign out_cout  = ctl_q[NSEG-1].carry;
    assign out_err   = ctl_q[NSEG-1].err;
    assign tot_cnt   = tot_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bmf_adder_pipe.sv
// Directed bench for bmf_adder_pipe (WIDTH=32, SEG=8); a second instance with
// CW=2 shares all inputs to observe counter saturation.
module tb_bmf_adder_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SEG   = 8;
    localparam int unsigned NSEG  = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [3:0]  mode;
        logic [31:0] sum;
        logic        cout;
        logic        err;
    } vec_t;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic [WIDTH-1:0]  in_a      = '0;
    logic [WIDTH-1:0]  in_b      = '0;
    logic              in_cin    = 1'b0;
    logic [NSEG-1:0]   in_mode   = '0;
    logic              out_ready = 1'b1;
    logic              clr_stats = 1'b0;
    logic              in_ready, out_valid, out_cout, out_err;
    logic [WIDTH-1:0]  out_sum;
    logic [15:0]       tot_cnt, err_cnt;
    logic              in_ready2, out_valid2, out_cout2, out_err2;
    logic [WIDTH-1:0]  out_sum2;
    logic [1:0]        tot_cnt2, err_cnt2;

    int errors = 0;
    int checks = 0;
    int exp_tot = 0;
    int exp_err = 0;
    vec_t tbl[10];
    vec_t sq[$];

    always #5 clk = ~clk;

    bmf_adder_pipe #(.WIDTH(WIDTH), .SEG(SEG), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_err(out_err), .clr_stats(clr_stats),
        .tot_cnt(tot_cnt), .err_cnt(err_cnt)
    );

    bmf_adder_pipe #(.WIDTH(WIDTH), .SEG(SEG), .CW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode),
        .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
        .out_cout(out_cout2), .out_err(out_err2), .clr_stats(clr_stats),
        .tot_cnt(tot_cnt2), .err_cnt(err_cnt2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_cin   = v.cin;
        in_mode  = v.mode;
    endtask

    // Scramble operand inputs once nothing is offered
    task automatic idle_inputs();
        in_valid = 1'b0;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'h1234_5678;
        in_cin   = 1'b1;
        in_mode  = 4'hF;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) check({tag, " timeout"}, out_valid, 1);
    endtask

    // Streams sq through the DUT; out_ready low during cycles [stall_lo, stall_hi)
    task automatic stream(input int stall_lo, input int stall_hi, input string tag);
        int  sent = 0;
        int  got  = 0;
        int  c    = 0;
        bit  acc, xf;
        while (got < sq.size() && c < 200) begin
            out_ready = !(c >= stall_lo && c < stall_hi);
            if (sent < sq.size()) drive(sq[sent]);
            else idle_inputs();
            #1;
            if (!out_ready) begin
                check($sformatf("%s stall c%0d out_valid", tag, c), out_valid, 1);
                check($sformatf("%s stall c%0d in_ready", tag, c), in_ready, 0);
                check($sformatf("%s stall c%0d out_sum", tag, c), out_sum, sq[got].sum);
            end
            acc = in_valid && in_ready;
            xf  = out_valid && out_ready;
            if (xf) begin
                check($sformatf("%s beat%0d sum", tag, got), out_sum, sq[got].sum);
                check($sformatf("%s beat%0d cout", tag, got), out_cout, sq[got].cout);
                check($sformatf("%s beat%0d err", tag, got), out_err, sq[got].err);
            end
            tick();
            if (acc) sent++;
            if (xf) got++;
            c++;
        end
        idle_inputs();
        out_ready = 1'b1;
        check({tag, " delivered"}, got, sq.size());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vec_t v;

        tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 4'b0000, 32'h0000_0100, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 4'b0010, 32'h0000_0000, 1'b0, 1'b1};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000, 1'b1, 1'b0};
        tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'b0001, 32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 4'b1111, 32'h2345_6789, 1'b0, 1'b0};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b0};
        tbl[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 4'b0100, 32'h0100_0100, 1'b0, 1'b0};
        tbl[7] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'b1110, 32'h7FFF_FF00, 1'b0, 1'b1};
        tbl[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'b0000, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'b1111, 32'hFEFE_FEFE, 1'b1, 1'b1};

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset tot_cnt", tot_cnt, 0);
        check("reset err_cnt", err_cnt, 0);

        // Table: one beat at a time, latency and result per vector
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            #1;
            check($sformatf("vec%0d in_ready", i), in_ready, 1);
            tick();
            idle_inputs();
            lat = 1;
            while (!out_valid && lat < 12) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d latency", i), lat, NSEG);
            check($sformatf("vec%0d sum", i), out_sum, tbl[i].sum);
            check($sformatf("vec%0d cout", i), out_cout, tbl[i].cout);
            check($sformatf("vec%0d err", i), out_err, tbl[i].err);
            exp_tot++;
            if (tbl[i].err) exp_err++;
            tick();
            check($sformatf("vec%0d drained", i), out_valid, 0);
        end
        check("table tot_cnt", tot_cnt, exp_tot);
        check("table err_cnt", err_cnt, exp_err);

        // Eight-beat stream with a 3-cycle output stall once the pipe is full
        sq.delete();
        for (int i = 0; i < 8; i++) begin
            logic [32:0] s;
            v.a    = 32'h0000_00F0 + 32'(i) * 32'h0100_0001;
            v.b    = 32'(i) * 32'h0000_0020;
            v.cin  = 1'b0;
            v.mode = 4'b0000;
            s      = {1'b0, v.a} + {1'b0, v.b};
            v.sum  = s[31:0];
            v.cout = s[32];
            v.err  = 1'b0;
            sq.push_back(v);
        end
        stream(6, 9, "strm");
        exp_tot += 8;
        check("strm tot_cnt", tot_cnt, exp_tot);
        check("strm err_cnt", err_cnt, exp_err);

        // Reset with three beats in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i]);
            tick();
        end
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 1);
        check("rst tot_cnt", tot_cnt, 0);
        check("rst err_cnt", err_cnt, 0);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) lat++;
            tick();
        end
        check("rst stale beats", lat, 0);

        // Single erroneous transfer, then one coinciding with clr_stats
        out_ready = 1'b0;
        drive(tbl[1]);
        tick();
        idle_inputs();
        wait_valid("clr1");
        check("clr1 err", out_err, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("clr1 tot_cnt", tot_cnt, 1);
        check("clr1 err_cnt", err_cnt, 1);
        drive(tbl[1]);
        tick();
        idle_inputs();
        wait_valid("clr2");
        check("clr2 err", out_err, 1);
        out_ready = 1'b1;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr2 tot_cnt", tot_cnt, 0);
        check("clr2 err_cnt", err_cnt, 0);
        check("clr2 tot_cnt2", tot_cnt2, 0);
        check("clr2 err_cnt2", err_cnt2, 0);

        // Five errors back to back (CW=2 saturates), then a mode change on
        // identical operands that must not touch the beats already in flight
        sq.delete();
        for (int i = 0; i < 5; i++) sq.push_back(tbl[1]);
        sq.push_back(tbl[0]);
        stream(-1, -1, "sat");
        tick();
        check("sat tot_cnt", tot_cnt, 6);
        check("sat err_cnt", err_cnt, 5);
        check("sat tot_cnt2", tot_cnt2, 3);
        check("sat err_cnt2", err_cnt2, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bmf_adder_pipe.md
BMF_ADDER_PIPE -- requirements
Module: bmf_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 Parameter SEG, default 8, segment width in bits; WIDTH SHALL be a multiple of SEG; NSEG = WIDTH/SEG.
REQ-003 Parameter CW, default 16, width of statistics counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 in_a, in_b  input  WIDTH  operands.
REQ-009 in_cin  input  1  carry-in.
REQ-010 in_mode  input  NSEG  per-segment mode; bit i=1 makes segment i approximate.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_sum  output  WIDTH  (approximate) sum.
REQ-014 out_cout  output  1  carry-out of top segment.
REQ-015 out_err  output  1  out_sum/out_cout differ from exact a+b+cin.
REQ-016 clr_stats  input  1  synchronous clear of statistics.
REQ-017 tot_cnt, err_cnt  output  CW each  results delivered / erroneous results delivered.

Function
REQ-018 Pipeline SHALL have NSEG stages; stage i adds segment i (bits i*SEG .. i*SEG+SEG-1) and registers it with the remaining operand bits, mode, and the stage's carry-out.
REQ-019 Exact segment: carry-in = carry-out of segment i-1 (in_cin for i=0).
REQ-020 Approximate segment: carry-in forced to 0 (carry cut), regardless of preceding carry.
REQ-021 A shadow exact carry chain SHALL travel alongside; out_err = 1 iff {out_cout,out_sum} != a+b+cin (WIDTH+1 bits).
REQ-022 Latency: beat accepted in cycle t appears with out_valid=1 in cycle t+NSEG if no stall.
REQ-023 Global advance = out_ready | ~out_valid; in_ready = advance; all stages hold when advance=0.
REQ-024 Bubbles (in_valid=0 when accepted) SHALL propagate as invalid stages; per-stage valid bit required.
REQ-025 Beat transfers on input when in_valid & in_ready; on output when out_valid & out_ready; no beat lost or duplicated under any out_ready pattern.
REQ-026 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 On each output transfer tot_cnt += 1 and err_cnt += out_err, each saturating at 2^CW-1.
REQ-028 clr_stats=1 sets both counters to 0 next cycle; clear wins over a simultaneous increment.
REQ-029 Mode travels with its beat; changing in_mode never affects beats already accepted.

Reset
REQ-030 rst_n=0 at a clock edge SHALL clear all stage valid bits, out_valid, tot_cnt, err_cnt; data registers need no reset.
REQ-031 Reset mid-operation discards all in-flight beats; out_valid=0 in first cycle after reset deassertion.
REQ-032 in_ready SHALL be 1 in the first cycle after reset (pipeline empty).

Structure
REQ-033 Package bmf_adder_pkg SHALL hold NSEG computation function, stage record typedef (valid, mode, partial sum, carries), and default parameter constants.
REQ-034 One sub-module bmf_adder_seg (SEG-bit segment adder with mode-selected carry-in, exact shadow carry out) SHALL be instantiated NSEG times.

Verification (WIDTH=32, SEG=8)
REQ-035 a=0x000000FF, b=0x1, cin=0, mode=0000 -> 4 cycles later sum=0x00000100, cout=0, err=0.
REQ-036 Same operands, mode=0010 -> sum=0x00000000, err=1; err_cnt=1, tot_cnt=1 after transfer.
REQ-037 a=0xFFFFFFFF, b=0x0, cin=1, mode=0000 -> sum=0x00000000, cout=1, err=0; mode=0001 -> sum=0xFFFFFFFF, cout=0, err=1.
REQ-038 Stream 8 beats, hold out_ready=0 for 3 cycles when pipe full -> in_ready=0, out_sum constant, all 8 results delivered in order.
REQ-039 Assert rst_n=0 for one cycle with 3 beats in flight -> no out_valid afterwards for those beats; counters 0.
REQ-040 clr_stats=1 in same cycle as erroneous output transfer -> tot_cnt=err_cnt=0 next cycle; CW=2 run of 5 errors -> err_cnt saturates at 3.
